// File: rtl/dcache_port_arb_if.sv
// Bundle of every signal between the Dcache port arbiter and its neighbours:
// the LSQ load request, the ROB store-retire slots, and the Dcache command bus.
// The arbiter uses the slave modport. A driver or model on the other side uses master.
interface dcache_port_arb_if #(
  parameter int BIT_CSB = 2
);
  // LSQ load request
  logic             lsq_rd_mem;
  logic [63:0]      lsq_addr;
  logic [6:0]       lsq_pr_idx;
  logic [4:0]       lsq_ar_idx;
  // ROB retiring stores (slot 0 is older)
  logic             rob_retire_st0;
  logic             rob_retire_st1;
  logic [63:0]      st_addr0;
  logic [63:0]      st_value0;
  logic [63:0]      st_addr1;
  logic [63:0]      st_value1;
  // Dcache back-pressure
  logic             Dcache_busy;
  // Arbiter outputs
  logic             lsq_Dcache_avail;
  logic [BIT_CSB:0] csb_space;
  logic             Dcache_rd_mem;
  logic             Dcache_wr_mem;
  logic [63:0]      Dcache_addr;
  logic [63:0]      Dcache_st_value;
  logic [6:0]       Dcache_pr_idx;
  logic [4:0]       Dcache_ar_idx;
  logic             fwd_valid;
  logic [6:0]       fwd_pr_idx;
  logic [4:0]       fwd_ar_idx;
  logic [63:0]      fwd_value;

  modport slave (
    input  lsq_rd_mem, lsq_addr, lsq_pr_idx, lsq_ar_idx,
    input  rob_retire_st0, rob_retire_st1, st_addr0, st_value0, st_addr1, st_value1,
    input  Dcache_busy,
    output lsq_Dcache_avail, csb_space,
    output Dcache_rd_mem, Dcache_wr_mem, Dcache_addr, Dcache_st_value,
    output Dcache_pr_idx, Dcache_ar_idx,
    output fwd_valid, fwd_pr_idx, fwd_ar_idx, fwd_value
  );

  modport master (
    output lsq_rd_mem, lsq_addr, lsq_pr_idx, lsq_ar_idx,
    output rob_retire_st0, rob_retire_st1, st_addr0, st_value0, st_addr1, st_value1,
    output Dcache_busy,
    input  lsq_Dcache_avail, csb_space,
    input  Dcache_rd_mem, Dcache_wr_mem, Dcache_addr, Dcache_st_value,
    input  Dcache_pr_idx, Dcache_ar_idx,
    input  fwd_valid, fwd_pr_idx, fwd_ar_idx, fwd_value
  );
endinterface

// File: rtl/dcache_port_arb.sv
// Dcache port arbiter. One Dcache port is shared between LSQ load misses and
// retired stores. Retired stores wait in a committed-store buffer (CSB) and
// drain in order. Loads win the port by default. A starvation counter or a
// full CSB forces a DRAIN phase. A load that hits a CSB entry is answered by
// forwarding from that entry and does not use the Dcache port.

// Protocol checker: the ROB must never retire more stores than csb_space
// allows, and the arbiter must never issue a load and a store together.
module dcache_port_arb_chk #(
  parameter int BIT_CSB = 2
) (
  input logic             clock,
  input logic             reset,
  input logic             st0_i,
  input logic             st1_i,
  input logic [BIT_CSB:0] space_i,
  input logic             rd_i,
  input logic             wr_i
);
  logic [BIT_CSB+1:0] push_n_s;
  assign push_n_s = (BIT_CSB+2)'(st0_i) + (BIT_CSB+2)'(st1_i);

  a_push_fits: assert property (@(posedge clock) disable iff (reset)
    push_n_s <= (BIT_CSB+2)'(space_i));
  a_one_cmd: assert property (@(posedge clock) disable iff (reset)
    !(rd_i && wr_i));
endmodule

module dcache_port_arb #(
  parameter int LEN_CSB    = 4,
  parameter int BIT_CSB    = 2,
  parameter int STARVE_MAX = 8,
  parameter int LOW_MARK   = 1
) (
  input logic         clock,
  input logic         reset,
  dcache_port_arb_if.slave bus
);
  localparam int               STW         = $clog2(STARVE_MAX + 1);
  localparam logic [BIT_CSB:0] LEN_C       = (BIT_CSB+1)'(LEN_CSB);
  localparam logic [BIT_CSB:0] LOW_C       = (BIT_CSB+1)'(LOW_MARK);
  localparam logic [STW-1:0]   STARVE_C    = STW'(STARVE_MAX);
  localparam logic [0:0]       MODE_NORMAL = 1'b0;
  localparam logic [0:0]       MODE_DRAIN  = 1'b1;

  // CSB storage and bookkeeping
  logic [63:0]        csb_addr_q [LEN_CSB];
  logic [63:0]        csb_val_q  [LEN_CSB];
  logic [BIT_CSB-1:0] head_q, head_d;
  logic [BIT_CSB-1:0] tail_q, tail_d;
  logic [BIT_CSB:0]   count_q, count_d;
  logic [STW-1:0]     starve_q, starve_d;
  logic [0:0]         mode_q, mode_d;

  // Registered command and forward outputs
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] stv_q, stv_d;
  logic [6:0]  pr_q, pr_d;
  logic [4:0]  ar_q, ar_d;
  logic        fv_q, fv_d;
  logic [6:0]  fpr_q, fpr_d;
  logic [4:0]  far_q, far_d;
  logic [63:0] fval_q, fval_d;

  // Per-cycle decision signals
  logic               avail_s;
  logic               ld_req_s;
  logic               hit_s;
  logic [BIT_CSB-1:0] hit_idx_s;
  logic               fwd_s;
  logic               ld_issue_s;
  logic               pop_s;
  logic [BIT_CSB:0]   push_cnt_s;
  logic [BIT_CSB-1:0] tail1_s;

  // Loads are accepted only in NORMAL mode and only while the Dcache is free.
  // A request that arrives while the port is unavailable is ignored.
  assign avail_s    = ~bus.Dcache_busy & (mode_q == MODE_NORMAL);
  assign ld_req_s   = bus.lsq_rd_mem & avail_s;
  assign push_cnt_s = (BIT_CSB+1)'(bus.rob_retire_st0) + (BIT_CSB+1)'(bus.rob_retire_st1);
  assign tail1_s    = tail_q + BIT_CSB'(bus.rob_retire_st0);

  // Search the live CSB entries from oldest to youngest. The last match wins,
  // so the forwarded data is the youngest store to that address.
  always_comb begin
    logic match_v;
    hit_s     = 1'b0;
    hit_idx_s = '0;
    for (int k = 0; k < LEN_CSB; k++) begin
      match_v   = ((BIT_CSB+1)'(k) < count_q) &&
                  (csb_addr_q[head_q + BIT_CSB'(k)] == bus.lsq_addr);
      hit_idx_s = match_v ? (head_q + BIT_CSB'(k)) : hit_idx_s;
      hit_s     = hit_s | match_v;
    end
  end

  // A forwarded load leaves the Dcache port free, so a store can pop that cycle.
  assign fwd_s      = ld_req_s & hit_s;
  assign ld_issue_s = ld_req_s & ~hit_s;
  assign pop_s      = ~ld_issue_s & ~bus.Dcache_busy & (count_q != '0);

  // Pointer and occupancy update. Push and pop can happen in the same cycle.
  always_comb begin
    head_d  = head_q + BIT_CSB'(pop_s);
    tail_d  = tail_q + push_cnt_s[BIT_CSB-1:0];
    count_d = count_q + push_cnt_s - (BIT_CSB+1)'(pop_s);
  end

  // Count consecutive load wins that leave stores waiting. Any drain or an empty CSB resets the count.
  always_comb begin
    if (pop_s || (count_q == '0)) begin
      starve_d = '0;
    end else if (ld_issue_s && (starve_q != STARVE_C)) begin
      starve_d = starve_q + STW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Enter DRAIN on a full CSB or a starved CSB. Leave DRAIN once occupancy falls to the low mark.
  always_comb begin
    case (mode_q)
      MODE_NORMAL: begin
        if ((count_d == LEN_C) || (starve_d == STARVE_C)) begin
          mode_d = MODE_DRAIN;
        end else begin
          mode_d = MODE_NORMAL;
        end
      end
      MODE_DRAIN: begin
        if (count_d <= LOW_C) begin
          mode_d = MODE_NORMAL;
        end else begin
          mode_d = MODE_DRAIN;
        end
      end
      default: mode_d = MODE_NORMAL;
    endcase
  end

  // Build next-cycle command: a load wins the port, else the CSB head drains, else idle with zeroed fields.
  always_comb begin
    rd_d   = 1'b0;
    wr_d   = 1'b0;
    addr_d = 64'd0;
    stv_d  = 64'd0;
    pr_d   = 7'd0;
    ar_d   = 5'd0;
    if (ld_issue_s) begin
      rd_d   = 1'b1;
      addr_d = bus.lsq_addr;
      pr_d   = bus.lsq_pr_idx;
      ar_d   = bus.lsq_ar_idx;
    end else if (pop_s) begin
      wr_d   = 1'b1;
      addr_d = csb_addr_q[head_q];
      stv_d  = csb_val_q[head_q];
    end else begin
      rd_d   = 1'b0;
      wr_d   = 1'b0;
    end
  end

  // Build next-cycle forward completion: carries the load tags and the matched store data.
  always_comb begin
    fv_d   = 1'b0;
    fpr_d  = 7'd0;
    far_d  = 5'd0;
    fval_d = 64'd0;
    if (fwd_s) begin
      fv_d   = 1'b1;
      fpr_d  = bus.lsq_pr_idx;
      far_d  = bus.lsq_ar_idx;
      fval_d = csb_val_q[hit_idx_s];
    end else begin
      fv_d   = 1'b0;
    end
  end

  // Write retiring stores into the CSB at tail. Slot 0 is written first, so it is the older entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LEN_CSB; i++) begin
        csb_addr_q[i] <= 64'd0;
        csb_val_q[i]  <= 64'd0;
      end
    end else begin
      if (bus.rob_retire_st0) begin
        csb_addr_q[tail_q] <= bus.st_addr0;
        csb_val_q[tail_q]  <= bus.st_value0;
      end
      if (bus.rob_retire_st1) begin
        csb_addr_q[tail1_s] <= bus.st_addr1;
        csb_val_q[tail1_s]  <= bus.st_value1;
      end
    end
  end

  // Control state and registered outputs. Reset empties the CSB and cancels any command in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      mode_q   <= MODE_NORMAL;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 64'd0;
      stv_q    <= 64'd0;
      pr_q     <= 7'd0;
      ar_q     <= 5'd0;
      fv_q     <= 1'b0;
      fpr_q    <= 7'd0;
      far_q    <= 5'd0;
      fval_q   <= 64'd0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      mode_q   <= mode_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      stv_q    <= stv_d;
      pr_q     <= pr_d;
      ar_q     <= ar_d;
      fv_q     <= fv_d;
      fpr_q    <= fpr_d;
      far_q    <= far_d;
      fval_q   <= fval_d;
    end
  end

  assign bus.lsq_Dcache_avail = avail_s;
  assign bus.csb_space        = LEN_C - count_q;
  assign bus.Dcache_rd_mem    = rd_q;
  assign bus.Dcache_wr_mem    = wr_q;
  assign bus.Dcache_addr      = addr_q;
  assign bus.Dcache_st_value  = stv_q;
  assign bus.Dcache_pr_idx    = pr_q;
  assign bus.Dcache_ar_idx    = ar_q;
  assign bus.fwd_valid        = fv_q;
  assign bus.fwd_pr_idx       = fpr_q;
  assign bus.fwd_ar_idx       = far_q;
  assign bus.fwd_value        = fval_q;

  dcache_port_arb_chk #(.BIT_CSB(BIT_CSB)) u_chk (
    .clock   (clock),
    .reset   (reset),
    .st0_i   (bus.rob_retire_st0),
    .st1_i   (bus.rob_retire_st1),
    .space_i (bus.csb_space),
    .rd_i    (rd_q),
    .wr_i    (wr_q)
  );
endmodule

// File: tb/tb_dcache_port_arb.sv
// Self-checking bench for dcache_port_arb. It runs a table of directed
// vectors, hand-written multi-cycle sequences (starvation, fill/drain,
// asynchronous reset), and a randomized run checked against a queue-based model.
module tb_dcache_port_arb;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  dcache_port_arb_if #(.BIT_CSB(2)) bus ();

  dcache_port_arb #(
    .LEN_CSB(4), .BIT_CSB(2), .STARVE_MAX(8), .LOW_MARK(1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rd;  logic [63:0] addr; logic [6:0] pr; logic [4:0] ar;
    logic        st0; logic [63:0] a0;   logic [63:0] v0;
    logic        st1; logic [63:0] a1;   logic [63:0] v1;
    logic        busy;
    logic        e_rd; logic e_wr; logic [63:0] e_addr; logic [63:0] e_val;
    logic [6:0]  e_pr; logic [4:0] e_ar;
    logic        e_fv; logic [63:0] e_fval; logic [6:0] e_fpr; logic [4:0] e_far;
    logic [2:0]  e_space; logic e_avail;
  } vec_t;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] v;
  } ent_t;

  vec_t tbl [11];

  // Reference model state for the randomized phase
  ent_t mq [$];
  bit   m_drain;
  int   m_starve;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rd, input logic [63:0] addr, input logic [6:0] pr,
                       input logic [4:0] ar,
                       input logic s0, input logic [63:0] a0, input logic [63:0] v0,
                       input logic s1, input logic [63:0] a1, input logic [63:0] v1,
                       input logic busy);
    bus.lsq_rd_mem     = rd;
    bus.lsq_addr       = addr;
    bus.lsq_pr_idx     = pr;
    bus.lsq_ar_idx     = ar;
    bus.rob_retire_st0 = s0;
    bus.st_addr0       = a0;
    bus.st_value0      = v0;
    bus.rob_retire_st1 = s1;
    bus.st_addr1       = a1;
    bus.st_value1      = v1;
    bus.Dcache_busy    = busy;
  endtask

  task automatic idle(input logic busy);
    drive(1'b0, 64'd0, 7'd0, 5'd0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, busy);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle(1'b0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic e_rd, input logic e_wr,
                            input logic [63:0] e_addr, input logic [63:0] e_val,
                            input logic [6:0] e_pr, input logic [4:0] e_ar,
                            input logic e_fv, input logic [63:0] e_fval,
                            input logic [6:0] e_fpr, input logic [4:0] e_far);
    chk({tag, "_rd"},   64'(bus.Dcache_rd_mem),   64'(e_rd));
    chk({tag, "_wr"},   64'(bus.Dcache_wr_mem),   64'(e_wr));
    chk({tag, "_addr"}, bus.Dcache_addr,          e_addr);
    chk({tag, "_val"},  bus.Dcache_st_value,      e_val);
    chk({tag, "_pr"},   64'(bus.Dcache_pr_idx),   64'(e_pr));
    chk({tag, "_ar"},   64'(bus.Dcache_ar_idx),   64'(e_ar));
    chk({tag, "_fv"},   64'(bus.fwd_valid),       64'(e_fv));
    if (e_fv) begin
      chk({tag, "_fval"}, bus.fwd_value,          e_fval);
      chk({tag, "_fpr"},  64'(bus.fwd_pr_idx),    64'(e_fpr));
      chk({tag, "_far"},  64'(bus.fwd_ar_idx),    64'(e_far));
    end
  endtask

  // Watchdog: the stimulus is bounded, but the bench must never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_busy, r_rd, r_s0, r_s1, hit, ldi, fwd, pop, m_avail;
    logic [63:0] r_addr, r_a0, r_v0, r_a1, r_v1, fval;
    logic [6:0]  r_pr;
    logic [4:0]  r_ar;
    ent_t        hd;
    int          space, npush, old;

    checks = 0;
    errors = 0;

    // Fields: rd addr pr ar | st0 a0 v0 | st1 a1 v1 | busy ||
    //         e_rd e_wr e_addr e_val e_pr e_ar | e_fv e_fval e_fpr e_far | e_space e_avail
    tbl[0]  = '{1'b0, 64'h0, 7'd0, 5'd0, 1'b1, 64'h100, 64'hAA, 1'b1, 64'h108, 64'hBB, 1'b0,
                1'b0, 1'b0, 64'h0, 64'h0, 7'd0, 5'd0, 1'b0, 64'h0, 7'd0, 5'd0, 3'd2, 1'b1};
    tbl[1]  = '{1'b0, 64'h0, 7'd0, 5'd0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0,
                1'b0, 1'b1, 64'h100, 64'hAA, 7'd0, 5'd0, 1'b0, 64'h0, 7'd0, 5'd0, 3'd3, 1'b1};
    tbl[2]  = '{1'b0, 64'h0, 7'd0, 5'd0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0,
                1'b0, 1'b1, 64'h108, 64'hBB, 7'd0, 5'd0, 1'b0, 64'h0, 7'd0, 5'd0, 3'd4, 1'b1};
    tbl[3]  = '{1'b0, 64'h0, 7'd0, 5'd0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0,
                1'b0, 1'b0, 64'h0, 64'h0, 7'd0, 5'd0, 1'b0, 64'h0, 7'd0, 5'd0, 3'd4, 1'b1};
    tbl[4]  = '{1'b0, 64'h0, 7'd0, 5'd0, 1'b1, 64'h200, 64'h11, 1'b1, 64'h200, 64'h22, 1'b1,
                1'b0, 1'b0, 64'h0, 64'h0, 7'd0, 5'd0, 1'b0, 64'h0, 7'd0, 5'd0, 3'd2, 1'b0};
    tbl[5]  = '{1'b0, 64'h0, 7'd0, 5'd0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b1,
                1'b0, 1'b0, 64'h0, 64'h0, 7'd0, 5'd0, 1'b0, 64'h0, 7'd0, 5'd0, 3'd2, 1'b0};
    tbl[6]  = '{1'b1, 64'h200, 7'd9, 5'd3, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0,
                1'b0, 1'b1, 64'h200, 64'h11, 7'd0, 5'd0, 1'b1, 64'h22, 7'd9, 5'd3, 3'd3, 1'b1};
    tbl[7]  = '{1'b1, 64'h200, 7'd5, 5'd1, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0,
                1'b0, 1'b1, 64'h200, 64'h22, 7'd0, 5'd0, 1'b1, 64'h22, 7'd5, 5'd1, 3'd4, 1'b1};
    tbl[8]  = '{1'b1, 64'h300, 7'd7, 5'd2, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0,
                1'b1, 1'b0, 64'h300, 64'h0, 7'd7, 5'd2, 1'b0, 64'h0, 7'd0, 5'd0, 3'd4, 1'b1};
    tbl[9]  = '{1'b1, 64'h300, 7'd7, 5'd2, 1'b1, 64'h300, 64'h55, 1'b0, 64'h0, 64'h0, 1'b0,
                1'b1, 1'b0, 64'h300, 64'h0, 7'd7, 5'd2, 1'b0, 64'h0, 7'd0, 5'd0, 3'd3, 1'b1};
    tbl[10] = '{1'b0, 64'h0, 7'd0, 5'd0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0,
                1'b0, 1'b1, 64'h300, 64'h55, 7'd0, 5'd0, 1'b0, 64'h0, 7'd0, 5'd0, 3'd4, 1'b1};

    // Reset state
    idle(1'b0);
    reset = 1'b1;
    #12;
    expect_out("rst", 1'b0, 1'b0, 64'h0, 64'h0, 7'd0, 5'd0, 1'b0, 64'h0, 7'd0, 5'd0);
    chk("rst_space", 64'(bus.csb_space), 64'd4);
    chk("rst_avail", 64'(bus.lsq_Dcache_avail), 64'd1);
    reset = 1'b0;

    // Directed vector table, applied back to back from reset
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].rd, tbl[i].addr, tbl[i].pr, tbl[i].ar,
            tbl[i].st0, tbl[i].a0, tbl[i].v0, tbl[i].st1, tbl[i].a1, tbl[i].v1, tbl[i].busy);
      tick();
      expect_out($sformatf("vec%0d", i), tbl[i].e_rd, tbl[i].e_wr, tbl[i].e_addr, tbl[i].e_val,
                 tbl[i].e_pr, tbl[i].e_ar, tbl[i].e_fv, tbl[i].e_fval, tbl[i].e_fpr, tbl[i].e_far);
      chk($sformatf("vec%0d_space", i), 64'(bus.csb_space), 64'(tbl[i].e_space));
      chk($sformatf("vec%0d_avail", i), 64'(bus.lsq_Dcache_avail), 64'(tbl[i].e_avail));
    end

    // Starvation: one waiting store, eight missing loads force a drain
    do_reset();
    drive(1'b0, 64'h0, 7'd0, 5'd0, 1'b1, 64'h400, 64'h77, 1'b0, 64'h0, 64'h0, 1'b0);
    tick();
    chk("stv_space", 64'(bus.csb_space), 64'd3);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 64'h500 + 64'(i) * 64'd8, 7'(i), 5'(i),
            1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0);
      tick();
      chk($sformatf("stv_ld%0d_rd", i), 64'(bus.Dcache_rd_mem), 64'd1);
      chk($sformatf("stv_ld%0d_wr", i), 64'(bus.Dcache_wr_mem), 64'd0);
      chk($sformatf("stv_ld%0d_avail", i), 64'(bus.lsq_Dcache_avail), (i < 7) ? 64'd1 : 64'd0);
    end
    idle(1'b0);
    tick();
    expect_out("stv_pop", 1'b0, 1'b1, 64'h400, 64'h77, 7'd0, 5'd0, 1'b0, 64'h0, 7'd0, 5'd0);
    chk("stv_back_avail", 64'(bus.lsq_Dcache_avail), 64'd1);
    chk("stv_back_space", 64'(bus.csb_space), 64'd4);

    // Fill to full while busy, then drain down to the low mark
    do_reset();
    drive(1'b0, 64'h0, 7'd0, 5'd0, 1'b1, 64'h600, 64'h1, 1'b1, 64'h608, 64'h2, 1'b1);
    tick();
    drive(1'b0, 64'h0, 7'd0, 5'd0, 1'b1, 64'h610, 64'h3, 1'b1, 64'h618, 64'h4, 1'b1);
    tick();
    chk("full_space", 64'(bus.csb_space), 64'd0);
    idle(1'b0);
    #1;
    chk("full_drain_avail", 64'(bus.lsq_Dcache_avail), 64'd0);
    tick();
    expect_out("drn0", 1'b0, 1'b1, 64'h600, 64'h1, 7'd0, 5'd0, 1'b0, 64'h0, 7'd0, 5'd0);
    chk("drn0_avail", 64'(bus.lsq_Dcache_avail), 64'd0);
    tick();
    expect_out("drn1", 1'b0, 1'b1, 64'h608, 64'h2, 7'd0, 5'd0, 1'b0, 64'h0, 7'd0, 5'd0);
    chk("drn1_avail", 64'(bus.lsq_Dcache_avail), 64'd0);
    tick();
    expect_out("drn2", 1'b0, 1'b1, 64'h610, 64'h3, 7'd0, 5'd0, 1'b0, 64'h0, 7'd0, 5'd0);
    chk("drn2_avail", 64'(bus.lsq_Dcache_avail), 64'd1);
    chk("drn2_space", 64'(bus.csb_space), 64'd3);
    tick();
    expect_out("drn3", 1'b0, 1'b1, 64'h618, 64'h4, 7'd0, 5'd0, 1'b0, 64'h0, 7'd0, 5'd0);
    chk("drn3_space", 64'(bus.csb_space), 64'd4);

    // Asynchronous reset mid-cycle with three entries and a load in flight
    do_reset();
    drive(1'b0, 64'h0, 7'd0, 5'd0, 1'b1, 64'h700, 64'h5, 1'b1, 64'h708, 64'h6, 1'b1);
    tick();
    drive(1'b0, 64'h0, 7'd0, 5'd0, 1'b1, 64'h710, 64'h7, 1'b0, 64'h0, 64'h0, 1'b1);
    tick();
    drive(1'b1, 64'h7F0, 7'd12, 5'd4, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0);
    tick();
    chk("arst_pre_rd", 64'(bus.Dcache_rd_mem), 64'd1);
    chk("arst_pre_space", 64'(bus.csb_space), 64'd1);
    idle(1'b0);
    #2;
    reset = 1'b1;
    #1;
    expect_out("arst", 1'b0, 1'b0, 64'h0, 64'h0, 7'd0, 5'd0, 1'b0, 64'h0, 7'd0, 5'd0);
    chk("arst_space", 64'(bus.csb_space), 64'd4);
    #3;
    reset = 1'b0;
    tick();
    chk("arst_post_space", 64'(bus.csb_space), 64'd4);
    chk("arst_post_avail", 64'(bus.lsq_Dcache_avail), 64'd1);
    chk("arst_post_wr", 64'(bus.Dcache_wr_mem), 64'd0);

    // Randomized run against the queue-based reference model
    do_reset();
    mq.delete();
    m_drain  = 1'b0;
    m_starve = 0;
    for (int n = 0; n < 1500; n++) begin
      r_busy  = ($urandom_range(0, 3) == 0);
      m_avail = !r_busy && !m_drain;
      r_rd    = m_avail && ($urandom_range(0, 1) == 1);
      r_addr  = 64'h1000 + 64'($urandom_range(0, 5)) * 64'd8;
      r_pr    = 7'($urandom);
      r_ar    = 5'($urandom);
      space   = 4 - mq.size();
      npush   = $urandom_range(0, 2);
      if (npush > space) npush = space;
      r_s0    = (npush == 2) || ((npush == 1) && ($urandom_range(0, 1) == 0));
      r_s1    = (npush == 2) || ((npush == 1) && !r_s0);
      r_a0    = 64'h1000 + 64'($urandom_range(0, 5)) * 64'd8;
      r_a1    = 64'h1000 + 64'($urandom_range(0, 5)) * 64'd8;
      r_v0    = {$urandom, $urandom};
      r_v1    = {$urandom, $urandom};
      drive(r_rd, r_addr, r_pr, r_ar, r_s0, r_a0, r_v0, r_s1, r_a1, r_v1, r_busy);
      #1;
      chk("rnd_avail", 64'(bus.lsq_Dcache_avail), 64'(m_avail));
      chk("rnd_space", 64'(bus.csb_space), 64'(space));

      // Youngest matching store wins; stores pushed this cycle are not yet in mq.
      hit  = 1'b0;
      fval = 64'd0;
      if (r_rd) begin
        foreach (mq[i]) begin
          if (mq[i].a == r_addr) begin
            hit  = 1'b1;
            fval = mq[i].v;
          end
        end
      end
      ldi = r_rd && !hit;
      fwd = r_rd && hit;
      pop = !ldi && !r_busy && (mq.size() > 0);
      hd  = (mq.size() > 0) ? mq[0] : '0;

      tick();
      expect_out("rnd", ldi, pop,
                 ldi ? r_addr : (pop ? hd.a : 64'd0),
                 pop ? hd.v : 64'd0,
                 ldi ? r_pr : 7'd0, ldi ? r_ar : 5'd0,
                 fwd, fval, r_pr, r_ar);

      old = mq.size();
      if (pop) void'(mq.pop_front());
      if (r_s0) mq.push_back('{a: r_a0, v: r_v0});
      if (r_s1) mq.push_back('{a: r_a1, v: r_v1});
      if (pop || (old == 0)) m_starve = 0;
      else if (ldi && (m_starve < 8)) m_starve = m_starve + 1;
      if (!m_drain) m_drain = (mq.size() == 4) || (m_starve == 8);
      else          m_drain = (mq.size() > 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
